dmem_refill: RTL and testbench
==============================

Name: dmem_refill

Overview:
- Line-refill engine directly downstream of the data cache's external bus port.
- Accepts a cache-line fetch request (b_addr_d/b_rd_d) and issues one burst read on the system memory bus.
- Assembles the BUS_W-wide beats into a full DMEM_LINE-wide line and returns it with a single-cycle b_dv_d pulse.
- Sits between the dmem cache and the core's bus arbiter; read-only, no write-back path.

Parameters:
- BLK_LEN, 58, width of the block (line) address: tag+set bits.
- LINE_W, 512, cache line width in bits; must be a multiple of BUS_W.
- BUS_W, 64, memory bus data width in bits.
- BEATS, LINE_W/BUS_W (8), derived; beats per burst, power of two, at least 2.
- OFFS_W, log2(LINE_W/8) (6), derived; byte-offset bits appended to the block address.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- b_addr_d  in  BLK_LEN  block address of the requested line.
- b_rd_d  in  1  refill request; held high by the cache until b_dv_d.
- b_rdata_d  out  LINE_W  assembled line; beat 0 at bits [BUS_W-1:0].
- b_dv_d  out  1  line valid, one-cycle pulse.
- m_araddr  out  64  burst byte address = {zero-extend(b_addr latched), OFFS_W'b0}.
- m_arlen  out  8  burst length = BEATS-1, constant.
- m_arvalid  out  1  address valid.
- m_arready  in  1  address accepted.
- m_rdata  in  BUS_W  read beat data.
- m_rvalid  in  1  beat valid.
- m_rlast  in  1  final beat marker.
- m_rready  out  1  beat accept.
- refill_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async assert, sync-safe deassert): FSM=IDLE, beat counter=0, line buffer=0, latched address=0. Outputs: b_dv_d=0, b_rdata_d=0, m_arvalid=0, m_araddr=0, m_rready=0, refill_err=0. Reset mid-burst abandons the burst; the bus side is assumed to be reset together with this block.
- FSM states: IDLE, REQ, DATA, DONE.
- IDLE:
  - b_rd_d=1 latches b_addr_d and moves to REQ next cycle.
  - b_addr_d is ignored after the latch.
- REQ:
  - m_arvalid=1 and m_araddr stable until the handshake.
  - The cycle with m_arvalid && m_arready moves to DATA and clears the counter.
- DATA:
  - m_rready=1.
  - Each cycle with m_rvalid writes m_rdata to line slice [cnt*BUS_W +: BUS_W] and increments cnt.
  - Gaps (m_rvalid=0) hold the state.
  - On the beat where cnt==BEATS-1, go to DONE.
- DONE:
  - b_dv_d=1 for exactly one cycle, then IDLE.
  - b_rdata_d is the line register: valid in the DONE cycle and held until the next refill's first beat overwrites it.
- Latency: minimum BEATS+3 cycles from b_rd_d rising to b_dv_d, i.e. latch, REQ with arready=1, BEATS data cycles, DONE.
- Back-to-back requests: b_rd_d sampled high in the IDLE cycle right after DONE starts a new refill. The cache drops b_rd_d the cycle after b_dv_d, so there are no spurious repeats.
- b_rd_d dropping during REQ or DATA:
  - The burst still completes; there is no bus abort.
  - DONE is entered but b_dv_d is suppressed if b_rd_d=0 in the DONE cycle.
  - The line buffer is still updated.
- m_rlast checks:
  - m_rlast=1 on a beat with cnt!=BEATS-1 sets refill_err.
  - m_rlast=0 on beat BEATS-1 also sets refill_err.
  - The beat count, not m_rlast, terminates DATA.
  - refill_err clears only on reset.
- m_rvalid outside DATA is ignored (m_rready=0).
- Counter width is log2(BEATS); wrap from BEATS-1 to 0 occurs only on DATA exit.

Test Plan:
- Single refill: b_addr_d=58'h12, b_rd_d=1; arready=1 immediately; 8 beats of m_rdata=i (i=0..7, rlast on beat 7) -> m_araddr=64'h480, m_arlen=7; b_dv_d pulses once at cycle 11; b_rdata_d[64*i+:64]=i.
- Stalled bus: arready delayed 5 cycles; rvalid gaps after beats 2 and 5 -> m_araddr stable during the wait, b_dv_d delayed accordingly, data order correct, exactly one pulse.
- Back-to-back: second request (addr 58'h3F) asserted in the cycle after b_dv_d -> m_arvalid rises 2 cycles later with m_araddr=64'hFC0; b_rdata_d from the first line is held until the first beat of the second burst.
- Protocol error: m_rlast=1 on beat 3 -> refill_err=1; the remaining 4 beats are still consumed; b_dv_d pulses after beat 7; refill_err stays 1 until rst_n=0.
- Abandon: b_rd_d drops during DATA after beat 4 -> burst drains, no b_dv_d pulse, FSM returns to IDLE.
- Async reset mid-DATA: rst_n=0 between clock edges -> b_dv_d, m_arvalid and m_rready go to 0 immediately; after release, a new request completes normally.

Source files
------------

// File: rtl/dmem_refill.sv
// dmem_refill: line-refill engine for the data cache's external bus port.
// Takes one line fetch request, issues a single burst read on the memory bus,
// packs the BUS_W-wide beats into a LINE_W-wide line and returns it with a
// one-cycle valid pulse. Read-only; there is no write-back path.
//
// Ports
//   clk, rst_n     clock (rising edge), async active-low reset
//   b_addr_d       block address of the requested line (tag+set)
//   b_rd_d         refill request, held by the cache until b_dv_d
//   b_rdata_d      assembled line, beat 0 in the low BUS_W bits
//   b_dv_d         line valid, one-cycle pulse
//   m_araddr       burst byte address (block address with zero offset)
//   m_arlen        burst length, BEATS-1
//   m_arvalid      address valid
//   m_arready      address accepted
//   m_rdata        read beat data
//   m_rvalid       beat valid
//   m_rlast        final beat marker (checked, not used for termination)
//   m_rready       beat accept
//   refill_err     sticky beat/rlast disagreement flag, cleared by reset only
module dmem_refill #(
    parameter int unsigned BLK_LEN = 58,
    parameter int unsigned LINE_W  = 512,
    parameter int unsigned BUS_W   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BLK_LEN-1:0] b_addr_d,
    input  logic               b_rd_d,
    output logic [LINE_W-1:0]  b_rdata_d,
    output logic               b_dv_d,
    output logic [63:0]        m_araddr,
    output logic [7:0]         m_arlen,
    output logic               m_arvalid,
    input  logic               m_arready,
    input  logic [BUS_W-1:0]   m_rdata,
    input  logic               m_rvalid,
    input  logic               m_rlast,
    output logic               m_rready,
    output logic               refill_err
);

    localparam int unsigned BEATS  = LINE_W / BUS_W;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned OFFS_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BLK_LEN-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                err_q, err_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                last_beat;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    // Next-state, beat packing and protocol check
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (b_rd_d) begin
                    addr_d  = b_addr_d;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (m_arready) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (m_rvalid) begin
                    for (int b = 0; b < int'(BEATS); b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            line_d[b*BUS_W +: BUS_W] = m_rdata;
                        end
                    end
                    // rlast must appear on the final beat and only there
                    if (m_rlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered from the state being entered
        arvalid_d = (state_d == S_REQ);
        rready_d  = (state_d == S_DATA);
    end

    assign m_araddr   = 64'({addr_q, {OFFS_W{1'b0}}});
    assign m_arlen    = 8'(BEATS - 1);
    assign m_arvalid  = arvalid_q;
    assign m_rready   = rready_q;
    assign b_rdata_d  = line_q;
    assign refill_err = err_q;
    // A request withdrawn before completion gets no pulse even though the
    // burst drained, so the DONE pulse is qualified by the live request.
    assign b_dv_d     = (state_q == S_DONE) && b_rd_d;

endmodule

// File: tb/tb_dmem_refill.sv
// Self-checking bench for dmem_refill: drives scripted and randomized refills
// against a line/err model built from the beats the bench itself sends.
module tb_dmem_refill;

    localparam int BLK_LEN = 58;
    localparam int LINE_W  = 512;
    localparam int BUS_W   = 64;
    localparam int BEATS   = 8;
    localparam int VW      = 512;

    logic               clk;
    logic               rst_n;
    logic [BLK_LEN-1:0] b_addr_d;
    logic               b_rd_d;
    logic [LINE_W-1:0]  b_rdata_d;
    logic               b_dv_d;
    logic [63:0]        m_araddr;
    logic [7:0]         m_arlen;
    logic               m_arvalid;
    logic               m_arready;
    logic [BUS_W-1:0]   m_rdata;
    logic               m_rvalid;
    logic               m_rlast;
    logic               m_rready;
    logic               refill_err;

    dmem_refill #(
        .BLK_LEN(BLK_LEN),
        .LINE_W (LINE_W),
        .BUS_W  (BUS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b_addr_d  (b_addr_d),
        .b_rd_d    (b_rd_d),
        .b_rdata_d (b_rdata_d),
        .b_dv_d    (b_dv_d),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rvalid  (m_rvalid),
        .m_rlast   (m_rlast),
        .m_rready  (m_rready),
        .refill_err(refill_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                n_tests = 0;
    int                n_fail  = 0;
    int                gap_q[BEATS];
    logic [LINE_W-1:0] line_m;
    bit                err_m;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge, outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < BEATS; i++) gap_q[i] = 0;
    endtask

    // Bus noise while idle must be ignored
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            step();
            b_rd_d    = 1'b0;
            b_addr_d  = BLK_LEN'({$urandom, $urandom});
            m_arready = 1'($urandom);
            m_rvalid  = 1'b1;
            m_rdata   = {$urandom, $urandom};
            m_rlast   = 1'($urandom);
            sample();
            chk("idle_dv", VW'(b_dv_d), VW'(0));
            chk("idle_arvalid", VW'(m_arvalid), VW'(0));
            chk("idle_rready", VW'(m_rready), VW'(0));
            chk("idle_rdata", VW'(b_rdata_d), VW'(line_m));
            chk("idle_err", VW'(refill_err), VW'(err_m));
        end
    endtask

    // One refill: latch cycle, ar_delay stall cycles, beats with gap_q[] gaps, DONE.
    // bad_beat: beat whose rlast is inverted; drop_after: request withdrawn after
    // that beat; rst_after: async reset asserted after that beat (negative = none).
    task automatic do_refill(input logic [BLK_LEN-1:0] addr, input int ar_delay,
                             input bit idx_data, input int bad_beat,
                             input int drop_after, input int rst_after);
        logic [63:0]       exp_addr;
        logic [LINE_W-1:0] new_line;
        logic [BUS_W-1:0]  d;
        bit                want;
        exp_addr = 64'(addr) * 64'd64;
        new_line = line_m;
        want     = 1'b1;

        step();
        b_addr_d  = addr;
        b_rd_d    = 1'b1;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_arready = 1'b0;
        sample();
        chk("latch_arvalid", VW'(m_arvalid), VW'(0));
        chk("latch_dv", VW'(b_dv_d), VW'(0));

        for (int k = 0; k <= ar_delay; k++) begin
            step();
            b_addr_d  = BLK_LEN'({$urandom, $urandom});
            m_arready = (k == ar_delay);
            sample();
            chk("req_arvalid", VW'(m_arvalid), VW'(1));
            chk("req_araddr", VW'(m_araddr), VW'(exp_addr));
            chk("req_hold_rdata", VW'(b_rdata_d), VW'(line_m));
            if (k == 0) chk("arlen", VW'(m_arlen), VW'(BEATS - 1));
        end

        for (int i = 0; i < BEATS; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                step();
                b_rd_d    = want;
                m_arready = 1'b0;
                m_rvalid  = 1'b0;
                m_rdata   = {$urandom, $urandom};
                sample();
                chk("gap_rready", VW'(m_rready), VW'(1));
                chk("gap_dv", VW'(b_dv_d), VW'(0));
                chk("gap_rdata", VW'(b_rdata_d), VW'(new_line));
            end
            step();
            b_rd_d    = want;
            m_arready = 1'b0;
            d         = idx_data ? BUS_W'(i) : {$urandom, $urandom};
            m_rvalid  = 1'b1;
            m_rdata   = d;
            m_rlast   = (i == BEATS - 1) != (i == bad_beat);
            sample();
            chk("beat_rready", VW'(m_rready), VW'(1));
            chk("beat_arvalid", VW'(m_arvalid), VW'(0));
            chk("beat_rdata", VW'(b_rdata_d), VW'(new_line));
            new_line[i*BUS_W +: BUS_W] = d;
            if (m_rlast != (i == BEATS - 1)) err_m = 1'b1;
            if (i == drop_after) want = 1'b0;
            if (i == rst_after) begin
                step();
                m_rvalid = 1'b0;
                b_rd_d   = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("rst_dv", VW'(b_dv_d), VW'(0));
                chk("rst_arvalid", VW'(m_arvalid), VW'(0));
                chk("rst_rready", VW'(m_rready), VW'(0));
                chk("rst_rdata", VW'(b_rdata_d), VW'(0));
                chk("rst_araddr", VW'(m_araddr), VW'(0));
                line_m = '0;
                err_m  = 1'b0;
                sample();
                sample();
                rst_n = 1'b1;
                return;
            end
        end

        step();
        b_rd_d   = want;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        sample();
        chk("done_dv", VW'(b_dv_d), VW'(want));
        chk("done_rdata", VW'(b_rdata_d), VW'(new_line));
        chk("done_err", VW'(refill_err), VW'(err_m));
        chk("done_rready", VW'(m_rready), VW'(0));
        line_m = new_line;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        b_addr_d  = '0;
        b_rd_d    = 1'b0;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        line_m    = '0;
        err_m     = 1'b0;
        clear_gaps();
        repeat (3) sample();
        chk("rst0_dv", VW'(b_dv_d), VW'(0));
        chk("rst0_rdata", VW'(b_rdata_d), VW'(0));
        chk("rst0_arvalid", VW'(m_arvalid), VW'(0));
        chk("rst0_araddr", VW'(m_araddr), VW'(0));
        chk("rst0_rready", VW'(m_rready), VW'(0));
        chk("rst0_err", VW'(refill_err), VW'(0));
        rst_n = 1'b1;

        // Minimum-latency refill with beat i carrying value i
        do_refill(58'h12, 0, 1'b1, -1, -1, -1);
        idle(2);

        // Address stall and beat gaps
        gap_q[3] = 2;
        gap_q[6] = 1;
        do_refill(BLK_LEN'({$urandom, $urandom}), 5, 1'b0, -1, -1, -1);
        clear_gaps();
        idle(1);

        // Back-to-back: second request latched in the cycle after DONE
        do_refill(BLK_LEN'({$urandom, $urandom}), 0, 1'b0, -1, -1, -1);
        do_refill(58'h3F, 0, 1'b0, -1, -1, -1);
        idle(1);

        // Early rlast on beat 3: sticky error, burst still completes
        do_refill(BLK_LEN'({$urandom, $urandom}), 0, 1'b0, 3, -1, -1);
        idle(2);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < BEATS; i++) gap_q[i] = int'($urandom_range(0, 2));
            do_refill(BLK_LEN'({$urandom, $urandom}), int'($urandom_range(0, 3)), 1'b0,
                      (n == 2) ? BEATS - 1 : -1, -1, -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        clear_gaps();
        idle(1);

        // Request withdrawn after beat 4: drains without a pulse
        do_refill(BLK_LEN'({$urandom, $urandom}), 1, 1'b0, -1, 4, -1);
        idle(2);

        // Async reset mid-burst, then a clean refill
        do_refill(BLK_LEN'({$urandom, $urandom}), 0, 1'b0, -1, -1, 5);
        do_refill(BLK_LEN'({$urandom, $urandom}), 0, 1'b1, -1, -1, -1);
        idle(2);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < BEATS; i++) gap_q[i] = int'($urandom_range(0, 1));
            do_refill(BLK_LEN'({$urandom, $urandom}), int'($urandom_range(0, 2)), 1'b0,
                      -1, -1, -1);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
